// File: rtl/dec_syndrome_locator_pipe.sv
// Two-stage SECDED syndrome classifier and column locator with saturating
// single/double error statistics, placed between syndrome generation and bit correction.
module dec_syndrome_locator_pipe #(
    parameter int MAX_K = 5,
    parameter int SYN_W = MAX_K + 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYN_W-1:0] in_syn,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_status,
    output logic [MAX_K-1:0] out_col,
    output logic [CNT_W-1:0] cnt_single,
    output logic [CNT_W-1:0] cnt_double,
    input  logic             cnt_clr
);

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_SINGLE  = 2'b01;
    localparam logic [1:0] ST_DOUBLE  = 2'b10;
    localparam logic [1:0] ST_INVALID = 2'b11;

    logic             a_valid_q, a_valid_d;
    logic [SYN_W-1:0] a_syn_q, a_syn_d;
    logic [1:0]       a_mode_q, a_mode_d;
    logic             b_valid_q, b_valid_d;
    logic [1:0]       b_status_q, b_status_d;
    logic [MAX_K-1:0] b_col_q, b_col_d;
    logic [CNT_W-1:0] cnt_single_q, cnt_single_d;
    logic [CNT_W-1:0] cnt_double_q, cnt_double_d;

    logic [31:0]      k_s;
    logic [31:0]      msb_s;
    logic [SYN_W-1:0] h_s;
    logic             p_s;
    logic             hi_s;
    logic             pow2_s;
    logic [MAX_K-1:0] col_full_s;
    logic [1:0]       status_s;
    logic [MAX_K-1:0] col_s;
    logic             in_fire_s;
    logic             b_adv_s;
    logic             out_fire_s;

    // Stage A may only refuse when both slots are full and the result is stuck.
    assign in_ready   = !(a_valid_q && b_valid_q && !out_ready);
    assign in_fire_s  = in_valid && in_ready;
    assign b_adv_s    = !b_valid_q || out_ready;
    assign out_fire_s = b_valid_q && out_ready;

    assign out_valid  = b_valid_q;
    assign out_status = b_status_q;
    assign out_col    = b_col_q;
    assign cnt_single = cnt_single_q;
    assign cnt_double = cnt_double_q;

    // Split the stage-A syndrome into Hamming part, parity bit and high bits for its mode.
    always_comb begin
        k_s = 32'd5;
        case (a_mode_q)
            2'b00:   k_s = 32'd3;
            2'b01:   k_s = 32'd4;
            default: k_s = 32'd5;
        endcase
        k_s  = (k_s > 32'(MAX_K)) ? 32'(MAX_K) : k_s;
        h_s  = '0;
        p_s  = 1'b0;
        hi_s = 1'b0;
        for (int b = 0; b < SYN_W; b++) begin
            if ($unsigned(b) < k_s) begin
                h_s[b] = a_syn_q[b];
            end else if ($unsigned(b) == k_s) begin
                p_s = a_syn_q[b];
            end else begin
                hi_s = hi_s | a_syn_q[b];
            end
        end
    end

    // Classify and locate; non-power-of-two H ranks after the K+1 data-free columns,
    // and the count of powers of two below H is msb+1, giving col = K + H - msb - 1.
    always_comb begin
        msb_s = 32'd0;
        for (int i = 0; i < SYN_W; i++) begin
            if (h_s[i]) begin
                msb_s = 32'(i);
            end else begin
                msb_s = msb_s;
            end
        end
        pow2_s = ((h_s & (h_s - SYN_W'(1))) == '0);
        if (h_s == '0) begin
            col_full_s = MAX_K'(k_s);
        end else if (pow2_s) begin
            col_full_s = MAX_K'(msb_s);
        end else begin
            col_full_s = MAX_K'(k_s + 32'(h_s) - msb_s - 32'd1);
        end

        status_s = ST_NONE;
        col_s    = '0;
        if (a_syn_q == '0) begin
            status_s = ST_NONE;
        end else if (hi_s) begin
            status_s = ST_INVALID;
        end else if (!p_s) begin
            status_s = ST_DOUBLE;
        end else begin
            status_s = ST_SINGLE;
            col_s    = col_full_s;
        end
    end

    // Next-state for both pipeline stages and the statistics counters.
    always_comb begin
        a_valid_d  = a_valid_q;
        a_syn_d    = a_syn_q;
        a_mode_d   = a_mode_q;
        b_valid_d  = b_valid_q;
        b_status_d = b_status_q;
        b_col_d    = b_col_q;

        if (in_fire_s) begin
            a_valid_d = 1'b1;
            a_syn_d   = in_syn;
            a_mode_d  = in_mode;
        end else if (b_adv_s) begin
            a_valid_d = 1'b0;
        end else begin
            a_valid_d = a_valid_q;
        end

        if (b_adv_s) begin
            b_valid_d  = a_valid_q;
            b_status_d = a_valid_q ? status_s : ST_NONE;
            b_col_d    = a_valid_q ? col_s : '0;
        end else begin
            b_valid_d = b_valid_q;
        end

        cnt_single_d = cnt_single_q;
        cnt_double_d = cnt_double_q;
        if (cnt_clr) begin
            cnt_single_d = '0;
            cnt_double_d = '0;
        end else if (out_fire_s) begin
            if ((b_status_q == ST_SINGLE) && (cnt_single_q != '1)) begin
                cnt_single_d = cnt_single_q + CNT_W'(1);
            end else if (b_status_q[1] && (cnt_double_q != '1)) begin
                cnt_double_d = cnt_double_q + CNT_W'(1);
            end else begin
                cnt_single_d = cnt_single_q;
            end
        end else begin
            cnt_single_d = cnt_single_q;
        end
    end

    // State registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_valid_q    <= 1'b0;
            a_syn_q      <= '0;
            a_mode_q     <= 2'b00;
            b_valid_q    <= 1'b0;
            b_status_q   <= ST_NONE;
            b_col_q      <= '0;
            cnt_single_q <= '0;
            cnt_double_q <= '0;
        end else begin
            a_valid_q    <= a_valid_d;
            a_syn_q      <= a_syn_d;
            a_mode_q     <= a_mode_d;
            b_valid_q    <= b_valid_d;
            b_status_q   <= b_status_d;
            b_col_q      <= b_col_d;
            cnt_single_q <= cnt_single_d;
            cnt_double_q <= cnt_double_d;
        end
    end

endmodule

// File: tb/tb_dec_syndrome_locator_pipe.sv
// Randomised and directed checks of dec_syndrome_locator_pipe against a
// behavioural classifier/locator and an in-flight queue model.
module tb_dec_syndrome_locator_pipe;

    localparam int MAX_K = 5;
    localparam int SYN_W = 6;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [SYN_W-1:0] in_syn;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_status;
    logic [MAX_K-1:0] out_col;
    logic [CNT_W-1:0] cnt_single;
    logic [CNT_W-1:0] cnt_double;
    logic             cnt_clr;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];
    int m_single = 0;
    int m_double = 0;

    dec_syndrome_locator_pipe #(.MAX_K(MAX_K), .SYN_W(SYN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_syn(in_syn), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_status(out_status), .out_col(out_col), .cnt_single(cnt_single),
        .cnt_double(cnt_double), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    function automatic bit is_pow2(input int v);
        for (int j = 0; j < 31; j++) begin
            if (v == (1 << j)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Returns {status, col} for one syndrome under one mode.
    function automatic logic [6:0] ref_result(input logic [5:0] syn, input logic [1:0] md);
        int k, h, p, hi, col, n;
        k = (md == 2'b00) ? 3 : ((md == 2'b01) ? 4 : 5);
        if (k > MAX_K) k = MAX_K;
        h  = int'(syn) % (1 << k);
        p  = (int'(syn) >> k) & 1;
        hi = int'(syn) >> (k + 1);
        if (syn == 6'd0) return {2'b00, 5'd0};
        if (hi != 0) return {2'b11, 5'd0};
        if (p == 0) return {2'b10, 5'd0};
        if (h == 0) begin
            col = k;
        end else if (is_pow2(h)) begin
            col = 0;
            while ((1 << col) != h) col++;
        end else begin
            n = 0;
            for (int v = 3; v < h; v++) begin
                if (!is_pow2(v)) n++;
            end
            col = k + 1 + n;
        end
        return {2'b01, col[4:0]};
    endfunction

    task automatic step(input logic iv, input logic [5:0] syn, input logic [1:0] md,
                        input logic ordy, input logic clr,
                        output logic acc, output logic hs, output logic ov, output logic rdy,
                        output logic [1:0] st, output logic [4:0] col);
        @(negedge clk);
        in_valid  = iv;
        in_syn    = syn;
        in_mode   = md;
        out_ready = ordy;
        cnt_clr   = clr;
        #1;
        rdy = in_ready;
        ov  = out_valid;
        acc = iv && in_ready;
        hs  = out_valid && ordy;
        st  = out_status;
        col = out_col;
        if (acc) exp_q.push_back(ref_result(syn, md));
    endtask

    task automatic count_model(input logic hs, input logic clr, input logic [1:0] st);
        if (clr) begin
            m_single = 0;
            m_double = 0;
        end else if (hs) begin
            if (st == 2'b01) begin
                if (m_single < CMAX) m_single++;
            end else if (st[1]) begin
                if (m_double < CMAX) m_double++;
            end
        end
    endtask

    task automatic test_reset();
        logic acc, hs, ov, rdy;
        logic [1:0] st;
        logic [4:0] col;
        logic [6:0] e;
        rst = 1'b0; in_valid = 1'b0; in_syn = '0; in_mode = 2'b00; out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_status !== 2'b00 || out_col !== 5'd0) begin errors++; $display("FAIL reset_out got %b/%0d want 00/0", out_status, out_col); end
        checks++; if (cnt_single !== 4'd0 || cnt_double !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", cnt_single, cnt_double); end
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step(c == 0, 6'd0, 2'b00, 1'b1, 1'b0, acc, hs, ov, rdy, st, col);
            if (c == 0) begin
                checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", rdy); end
            end
            checks++; if (ov !== (c == 2)) begin errors++; $display("FAIL latency cycle %0d out_valid got %b want %b", c, ov, (c == 2)); end
            e = 7'd0;
            if (hs) begin
                e = exp_q.pop_front();
                checks++; if ({st, col} !== e) begin errors++; $display("FAIL none_result got %b/%0d want %b/%0d", st, col, e[6:5], e[4:0]); end
            end
            count_model(hs, 1'b0, e[6:5]);
        end
        checks++; if (cnt_single !== 4'd0 || cnt_double !== 4'd0) begin errors++; $display("FAIL none_cnt got %0d/%0d want 0/0", cnt_single, cnt_double); end
    endtask

    task automatic test_single_map();
        logic [5:0] syn_t [6] = '{6'b001001, 6'b001000, 6'b001111, 6'b100000, 6'b110001, 6'b111111};
        logic [1:0] md_t  [6] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b10};
        logic [4:0] col_t [6] = '{5'd0, 5'd3, 5'd7, 5'd5, 5'd17, 5'd31};
        logic acc, hs, ov, rdy;
        logic [1:0] st;
        logic [4:0] col;
        logic [6:0] e;
        int idx = 0;
        for (int c = 0; c < 12; c++) begin
            step(c < 6, (c < 6) ? syn_t[c % 6] : 6'd0, (c < 6) ? md_t[c % 6] : 2'b00, 1'b1, 1'b0,
                 acc, hs, ov, rdy, st, col);
            e = 7'd0;
            if (hs) begin
                e = exp_q.pop_front();
                checks++; if ({st, col} !== e) begin errors++; $display("FAIL single_model #%0d got %b/%0d want %b/%0d", idx, st, col, e[6:5], e[4:0]); end
                if (idx < 6) begin
                    checks++; if (st !== 2'b01 || col !== col_t[idx]) begin errors++; $display("FAIL single_map #%0d got %b/%0d want 01/%0d", idx, st, col, col_t[idx]); end
                end
                idx++;
            end
            count_model(hs, 1'b0, e[6:5]);
        end
        checks++; if (idx != 6) begin errors++; $display("FAIL single_count got %0d want 6", idx); end
        checks++; if (cnt_single !== 4'd6) begin errors++; $display("FAIL single_cnt got %0d want 6", cnt_single); end
    endtask

    task automatic test_double_invalid();
        logic acc, hs, ov, rdy;
        logic [1:0] st;
        logic [4:0] col;
        logic [6:0] e;
        int idx = 0;
        for (int c = 0; c < 6; c++) begin
            step(c < 2, (c == 0) ? 6'b000101 : 6'b010001, (c == 0) ? 2'b01 : 2'b00, 1'b1, 1'b0,
                 acc, hs, ov, rdy, st, col);
            e = 7'd0;
            if (hs) begin
                e = exp_q.pop_front();
                checks++;
                if (st !== ((idx == 0) ? 2'b10 : 2'b11) || col !== 5'd0 || {st, col} !== e) begin
                    errors++; $display("FAIL dbl_inv #%0d got %b/%0d want %b/0", idx, st, col, (idx == 0) ? 2'b10 : 2'b11);
                end
                idx++;
            end
            count_model(hs, 1'b0, e[6:5]);
        end
        checks++; if (cnt_double !== 4'd2) begin errors++; $display("FAIL dbl_cnt got %0d want 2", cnt_double); end
    endtask

    task automatic test_backpressure();
        logic [5:0] s [5];
        logic [1:0] m [5];
        logic acc, hs, ov, rdy, ordy, was_stall, saw_low;
        logic [1:0] st, pst;
        logic [4:0] col, pcol;
        logic [6:0] e;
        int sz, next, outs;
        for (int i = 0; i < 5; i++) begin
            s[i] = 6'($urandom_range(1, 63));
            m[i] = 2'($urandom_range(0, 3));
        end
        next = 0; outs = 0; was_stall = 1'b0; saw_low = 1'b0; pst = 2'b00; pcol = 5'd0;
        for (int c = 0; c < 30 && outs < 5; c++) begin
            ordy = !(c >= 3 && c < 7);
            sz = exp_q.size();
            step(next < 5, s[next % 5], m[next % 5], ordy, 1'b0, acc, hs, ov, rdy, st, col);
            checks++; if (rdy !== !(sz == 2 && !ordy)) begin errors++; $display("FAIL bp_ready cycle %0d got %b want %b", c, rdy, !(sz == 2 && !ordy)); end
            if (!rdy) saw_low = 1'b1;
            if (was_stall) begin
                checks++; if (ov !== 1'b1 || st !== pst || col !== pcol) begin errors++; $display("FAIL bp_stable cycle %0d got %b %b/%0d want 1 %b/%0d", c, ov, st, col, pst, pcol); end
            end
            was_stall = ov && !ordy; pst = st; pcol = col;
            if (acc) next++;
            e = 7'd0;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++; $display("FAIL bp_extra got %b/%0d want none", st, col);
                end else begin
                    e = exp_q.pop_front();
                    checks++; if ({st, col} !== e) begin errors++; $display("FAIL bp_order #%0d got %b/%0d want %b/%0d", outs, st, col, e[6:5], e[4:0]); end
                end
                outs++;
            end
            count_model(hs, 1'b0, e[6:5]);
        end
        checks++; if (!saw_low) begin errors++; $display("FAIL bp_ready_low got never want low"); end
        checks++; if (outs != 5) begin errors++; $display("FAIL bp_outs got %0d want 5", outs); end
    endtask

    task automatic test_back_to_back();
        logic acc, hs, ov, rdy, iv, ordy, clr;
        logic [1:0] st;
        logic [4:0] col;
        logic [6:0] e;
        int sz;
        for (int c = 0; c < 400; c++) begin
            iv   = (c < 380) && ($urandom_range(0, 3) != 0);
            ordy = (c >= 380) || ($urandom_range(0, 9) < 7);
            clr  = ($urandom_range(0, 39) == 0);
            sz = exp_q.size();
            step(iv, 6'($urandom), 2'($urandom), ordy, clr, acc, hs, ov, rdy, st, col);
            checks++; if (rdy !== !(sz == 2 && !ordy)) begin errors++; $display("FAIL rnd_ready cycle %0d got %b want %b", c, rdy, !(sz == 2 && !ordy)); end
            checks++; if (cnt_single !== 4'(m_single) || cnt_double !== 4'(m_double)) begin
                errors++; $display("FAIL rnd_cnt cycle %0d got %0d/%0d want %0d/%0d", c, cnt_single, cnt_double, m_single, m_double);
            end
            e = {st, col};
            if (hs) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++; $display("FAIL rnd_extra cycle %0d got %b/%0d want none", c, st, col);
                end else begin
                    e = exp_q.pop_front();
                    checks++; if ({st, col} !== e) begin errors++; $display("FAIL rnd_result cycle %0d got %b/%0d want %b/%0d", c, st, col, e[6:5], e[4:0]); end
                end
            end
            count_model(hs, clr, e[6:5]);
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_saturation();
        logic acc, hs, ov, rdy;
        logic [1:0] st;
        logic [4:0] col;
        logic [6:0] e;
        step(1'b0, 6'd0, 2'b00, 1'b1, 1'b1, acc, hs, ov, rdy, st, col);
        count_model(hs, 1'b1, 2'b00);
        for (int c = 0; c < 26; c++) begin
            step(c < 20, 6'b001001, 2'b00, 1'b1, 1'b0, acc, hs, ov, rdy, st, col);
            e = 7'd0;
            if (hs) begin
                e = exp_q.pop_front();
                checks++; if ({st, col} !== e) begin errors++; $display("FAIL sat_result got %b/%0d want %b/%0d", st, col, e[6:5], e[4:0]); end
            end
            count_model(hs, 1'b0, e[6:5]);
        end
        checks++; if (cnt_single !== 4'd15 || cnt_single !== 4'(m_single)) begin errors++; $display("FAIL sat_cnt got %0d want 15", cnt_single); end
        for (int c = 0; c < 5; c++) begin
            step(c == 0, 6'b001001, 2'b00, 1'b1, c == 2, acc, hs, ov, rdy, st, col);
            e = 7'd0;
            if (hs) e = exp_q.pop_front();
            if (c == 2) begin
                checks++; if (hs !== 1'b1) begin errors++; $display("FAIL clr_hs got %b want 1", hs); end
            end
            count_model(hs, c == 2, e[6:5]);
        end
        checks++; if (cnt_single !== 4'd0 || cnt_single !== 4'(m_single)) begin errors++; $display("FAIL clr_wins got %0d want 0", cnt_single); end
    endtask

    task automatic test_async_reset();
        logic acc, hs, ov, rdy;
        logic [1:0] st;
        logic [4:0] col;
        step(1'b1, 6'b001001, 2'b00, 1'b1, 1'b0, acc, hs, ov, rdy, st, col);
        step(1'b1, 6'b000101, 2'b01, 1'b1, 1'b0, acc, hs, ov, rdy, st, col);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_status !== 2'b00 || out_col !== 5'd0) begin
            errors++; $display("FAIL arst_out got %b %b/%0d want 0 00/0", out_valid, out_status, out_col);
        end
        checks++; if (cnt_single !== 4'd0 || cnt_double !== 4'd0) begin errors++; $display("FAIL arst_cnt got %0d/%0d want 0/0", cnt_single, cnt_double); end
        in_valid = 1'b0;
        exp_q.delete();
        m_single = 0;
        m_double = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 6'd0, 2'b00, 1'b1, 1'b0, acc, hs, ov, rdy, st, col);
            checks++; if (ov !== 1'b0) begin errors++; $display("FAIL arst_ghost cycle %0d got %b want 0", c, ov); end
        end
    endtask

    initial begin
        test_reset();
        test_single_map();
        test_double_invalid();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dec_syndrome_locator_pipe.md
Name: dec_syndrome_locator_pipe

Overview:
- Pipelined, parametrised syndrome classifier and column locator for the SECDED decoder path.
- Accepts one syndrome plus a codeword-width mode per transaction on a valid/ready handshake.
- Classifies each syndrome as no error, single error (with the codeword column index) or double/uncorrectable error.
- Keeps saturating single- and double-error statistics counters; sits between the syndrome generator and the bit-flip correction stage.

Parameters:
- MAX_K, 5, log2 of the largest supported codeword width (5 = 32 bits).
- SYN_W, MAX_K+1, syndrome width: MAX_K Hamming bits plus 1 overall-parity bit.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept an input this cycle.
- in_syn  in  SYN_W  syndrome.
- in_mode  in  2  codeword width: 00 = 8, 01 = 16, 1x = 32. Gives K = 3, 4 or 5, clipped to MAX_K.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_status  out  2  00 = none, 01 = single, 10 = double, 11 = invalid.
- out_col  out  MAX_K  erroneous column index; meaningful only when out_status is 01.
- cnt_single  out  CNT_W  accepted results with status 01.
- cnt_double  out  CNT_W  accepted results with status 10 or 11.
- cnt_clr  in  1  synchronous clear of both counters.

Behaviour:
- Reset (rst low, asynchronous): stage valids clear; out_valid=0, out_status=00, out_col=0, cnt_single=0, cnt_double=0. in_ready=1 from the first cycle after rst goes high.
- Reset asserted mid-operation discards all in-flight transactions with no output.
- Syndrome fields for mode K:
  - H = in_syn[K-1:0] (Hamming part).
  - P = in_syn[K] (overall parity bit).
  - Bits above K are "high bits".
- Classification:
  - 00 (none): all SYN_W bits zero.
  - 11 (invalid): any high bit set.
  - 10 (double): P=0 and H!=0.
  - 01 (single): P=1 (covers H=0).
- Column index when status is 01:
  - H=2^i gives col=i, for i in 0..K-1.
  - H=0 (parity bit only) gives col=K.
  - Otherwise H is a non-power-of-two value. col = K+1+n, where n is the ascending rank of H among the non-power-of-two values in 3..2^K-1. For K=3: H=3 gives 4, 5 gives 5, 6 gives 6, 7 gives 7.
  - The index range is 0..2^K-1.
- out_col is 0 whenever status is not 01.
- Pipeline: two register stages.
  - Stage A captures in_syn and in_mode on in_valid && in_ready.
  - Stage B captures the status and column computed from stage A.
  - Latency is exactly 2 cycles from input acceptance to out_valid, with no bubbles.
  - Throughput is 1 per cycle while out_ready=1.
- Backpressure:
  - in_ready = !(A_valid && B_valid && !out_ready).
  - Stage B holds while out_valid && !out_ready; out_status and out_col stay stable.
  - Stage A advances into B whenever B is empty or being accepted.
  - No transaction is ever dropped or duplicated.
- Mode is sampled per transaction. Different consecutive modes are legal and each result uses its own mode.
- Counters:
  - Update only on an output handshake (out_valid && out_ready).
  - Status 01 increments cnt_single; status 10 or 11 increments cnt_double.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - cnt_clr zeroes both counters and wins over a same-cycle increment; that increment is lost.

Test Plan:
- Reset release, then in_syn=0, mode=00, out_ready=1 → 2 cycles later out_valid=1, status=00, col=0; counters stay 0.
- Single-error map, mode=00:
  - in_syn=6'b001001 → col 0; 6'b001000 → col 3; 6'b001111 → col 7.
  - Mode=1x: in_syn=6'b100000 → col 5; 6'b110001 → col 17; 6'b111111 → col 31.
  - All with status 01.
- Double and invalid: mode=01, in_syn=6'b000101 → status 10. Mode=00, in_syn=6'b010001 → status 11. cnt_double=2.
- Backpressure: stream 5 syndromes at 1/cycle while holding out_ready=0 from cycle 3 for 4 cycles → in_ready falls after 2 transactions are buffered; all 5 results emerge in order with outputs stable while stalled.
- Saturation: CNT_W=4, 20 single-error transactions → cnt_single=15. cnt_clr asserted together with an accepted single → cnt_single=0.
- Async reset asserted with 2 transactions in flight → out_valid=0 immediately, no results appear after release.
